cricket_scorekeeper: RTL

Match-state engine that sits directly upstream of the score-to-BCD display converter. It accepts one debounced, single-cycle ball event per delivery and accumulates runs, wickets and legal balls for the current innings. It sequences innings 1, the innings break, innings 2 and game over. It drives the run/wicket binaries, the innings-over and game-over flags, and the winner bit that the display stage consumes.

---
 rtl/cricket_pkg.sv | 36 +++
 rtl/cricket_scorekeeper_innings_counter.sv | 100 ++++++++++
 rtl/cricket_scorekeeper.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/cricket_pkg.sv
// ---------------------------------------------------------------------------
// cricket_pkg
// Shared types and constants for the cricket scorekeeper block.
//   state_e        : match sequencing states (INN1, BREAK, INN2, DONE)
//   RUN_W / WKT_W  : widths of the run and wicket displays
//   BALL_W         : width of the ballCount display port
//   DEF_*          : default match-format parameters
//   TEAM1 / TEAM2  : encodings of the winner bit
//   clamp_runs()   : maps the 3-bit runs field onto 0..6
// ---------------------------------------------------------------------------
package cricket_pkg;

  localparam int RUN_W  = 8;
  localparam int WKT_W  = 4;
  localparam int BALL_W = 5;

  localparam int DEF_BALLS_PER_OVER = 6;
  localparam int DEF_MAX_OVERS      = 2;
  localparam int DEF_MAX_WICKETS    = 10;

  localparam logic TEAM1 = 1'b0;
  localparam logic TEAM2 = 1'b1;

  typedef enum logic [1:0] {
    INN1  = 2'd0,
    BREAK = 2'd1,
    INN2  = 2'd2,
    DONE  = 2'd3
  } state_e;

  // A runs field of 7 is not a legal score; it counts as a six.
  function automatic logic [2:0] clamp_runs(input logic [2:0] runs);
    return (runs == 3'd7) ? 3'd6 : runs;
  endfunction

endpackage

// File: rtl/cricket_scorekeeper_innings_counter.sv
// ---------------------------------------------------------------------------
// innings_counter
// Holds the current-innings runs, wickets and legal-ball registers and
// exposes both their present values and the values they take once the
// presented ball is applied, so the FSM can make its end-of-innings and
// chase decisions on post-update figures in the same cycle.
//
// Optional feature macro: CRICKET_EXTRAS_EN (adds extra_i).
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   accept_i           apply the presented ball this cycle
//   runs_i [2:0]       runs on the ball (7 treated as 6)
//   wicket_i           wicket fell on the ball
//   extra_i            (CRICKET_EXTRAS_EN) wide/no-ball: +1 run, not legal
//   clear_i            zero all counters (start of innings 2)
//   runs_o/wickets_o/balls_o           registered counters
//   runs_upd_o/wickets_upd_o/balls_upd_o counters after the presented ball
// ---------------------------------------------------------------------------
module innings_counter
  import cricket_pkg::*;
#(
  parameter int BALL_CNT_W = BALL_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  accept_i,
  input  logic [2:0]            runs_i,
  input  logic                  wicket_i,
`ifdef CRICKET_EXTRAS_EN
  input  logic                  extra_i,
`endif
  input  logic                  clear_i,
  output logic [RUN_W-1:0]      runs_o,
  output logic [WKT_W-1:0]      wickets_o,
  output logic [BALL_CNT_W-1:0] balls_o,
  output logic [RUN_W-1:0]      runs_upd_o,
  output logic [WKT_W-1:0]      wickets_upd_o,
  output logic [BALL_CNT_W-1:0] balls_upd_o
);

  logic [RUN_W-1:0]      runs_q,    runs_d;
  logic [WKT_W-1:0]      wickets_q, wickets_d;
  logic [BALL_CNT_W-1:0] balls_q,   balls_d;

  logic                  legal;
  logic [2:0]            add_runs;
  logic [RUN_W:0]        run_sum;

  // Post-update values, computed as if the presented ball is applied.
  always_comb begin
`ifdef CRICKET_EXTRAS_EN
    legal    = !extra_i;
    add_runs = extra_i ? 3'(clamp_runs(runs_i) + 3'd1) : clamp_runs(runs_i);
`else
    legal    = 1'b1;
    add_runs = clamp_runs(runs_i);
`endif
    // One extra bit of headroom catches the carry for saturation.
    run_sum       = {1'b0, runs_q} + {{(RUN_W-2){1'b0}}, add_runs};
    runs_upd_o    = run_sum[RUN_W] ? {RUN_W{1'b1}} : run_sum[RUN_W-1:0];
    // A wicket on an extra ball does not count.
    wickets_upd_o = (legal && wicket_i) ? wickets_q + WKT_W'(1) : wickets_q;
    balls_upd_o   = legal ? balls_q + BALL_CNT_W'(1) : balls_q;
  end

  always_comb begin
    runs_d    = runs_q;
    wickets_d = wickets_q;
    balls_d   = balls_q;
    if (clear_i) begin
      runs_d    = '0;
      wickets_d = '0;
      balls_d   = '0;
    end else if (accept_i) begin
      runs_d    = runs_upd_o;
      wickets_d = wickets_upd_o;
      balls_d   = balls_upd_o;
    end
  end

  // NOTE: non-blocking (<=) in clocked blocks so every register samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      runs_q    <= '0;
      wickets_q <= '0;
      balls_q   <= '0;
    end else begin
      runs_q    <= runs_d;
      wickets_q <= wickets_d;
      balls_q   <= balls_d;
    end
  end

  assign runs_o    = runs_q;
  assign wickets_o = wickets_q;
  assign balls_o   = balls_q;

endmodule

// File: rtl/cricket_scorekeeper.sv
// ---------------------------------------------------------------------------
// cricket_scorekeeper
// Match-state engine feeding the score-to-BCD display stage. Accumulates
// runs, wickets and legal balls per innings, sequences
// INN1 -> BREAK -> INN2 -> DONE, and decides the winner.
//
// Optional feature macro: CRICKET_EXTRAS_EN (adds the ballExtra input).
//
// Parameters: BALLS_PER_OVER, MAX_OVERS, MAX_WICKETS (MAX_WICKETS <= 15).
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   ballValid           one-cycle pulse, a delivery completed
//   ballRuns [2:0]      runs on the delivery (7 treated as 6)
//   ballWicket          wicket fell on the delivery
//   ballExtra           (CRICKET_EXTRAS_EN) wide/no-ball
//   startNext           one-cycle pulse, leave BREAK and start innings 2
//   binaryRuns [7:0]    current-innings runs, saturating at 255
//   binaryWickets [3:0] current-innings wickets
//   ballCount [4:0]     legal balls in current innings
//   inningOver          high only in BREAK
//   gameOver            high only in DONE
//   winner              0 = team 1, 1 = team 2; valid while gameOver
// ---------------------------------------------------------------------------
module cricket_scorekeeper
  import cricket_pkg::*;
#(
  parameter int BALLS_PER_OVER = DEF_BALLS_PER_OVER,
  parameter int MAX_OVERS      = DEF_MAX_OVERS,
  parameter int MAX_WICKETS    = DEF_MAX_WICKETS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ballValid,
  input  logic [2:0]        ballRuns,
  input  logic              ballWicket,
`ifdef CRICKET_EXTRAS_EN
  input  logic              ballExtra,
`endif
  input  logic              startNext,
  output logic [RUN_W-1:0]  binaryRuns,
  output logic [WKT_W-1:0]  binaryWickets,
  output logic [BALL_W-1:0] ballCount,
  output logic              inningOver,
  output logic              gameOver,
  output logic              winner
);

  localparam int BALL_LIMIT = BALLS_PER_OVER * MAX_OVERS;
  // The internal ball counter grows for long formats; the display port keeps
  // its fixed width.
  localparam int BALL_CNT_W = ($clog2(BALL_LIMIT + 1) > BALL_W) ?
                              $clog2(BALL_LIMIT + 1) : BALL_W;

  state_e           state_q, state_d;
  logic [RUN_W-1:0] target_q, target_d;
  logic             winner_q, winner_d;
  logic             inning_over_q;
  logic             game_over_q;

  logic                  accept;
  logic                  clear;
  logic                  innings_end;
  logic [RUN_W-1:0]      runs_cur, runs_upd;
  logic [WKT_W-1:0]      wkts_cur, wkts_upd;
  logic [BALL_CNT_W-1:0] balls_cur, balls_upd;

  // Balls only count while an innings is live; startNext only acts in BREAK,
  // and since BREAK never accepts balls, startNext always wins a collision.
  assign accept = ballValid && ((state_q == INN1) || (state_q == INN2));
  assign clear  = startNext && (state_q == BREAK);

  innings_counter #(
    .BALL_CNT_W(BALL_CNT_W)
  ) u_counter (
    .clk          (clk),
    .rst_n        (rst_n),
    .accept_i     (accept),
    .runs_i       (ballRuns),
    .wicket_i     (ballWicket),
`ifdef CRICKET_EXTRAS_EN
    .extra_i      (ballExtra),
`endif
    .clear_i      (clear),
    .runs_o       (runs_cur),
    .wickets_o    (wkts_cur),
    .balls_o      (balls_cur),
    .runs_upd_o   (runs_upd),
    .wickets_upd_o(wkts_upd),
    .balls_upd_o  (balls_upd)
  );

  // Innings closes on the ball that produces all-out or exhausts the balls.
  assign innings_end = (wkts_upd  == WKT_W'(MAX_WICKETS)) ||
                       (balls_upd == BALL_CNT_W'(BALL_LIMIT));

  always_comb begin
    // NOTE: every signal gets a default before the case, so no path leaves a
    // combinational output unassigned and no latch is inferred.
    state_d  = state_q;
    target_d = target_q;
    winner_d = winner_q;
    unique case (state_q)
      INN1: begin
        if (accept && innings_end) begin
          target_d = runs_upd;
          state_d  = BREAK;
        end
      end
      BREAK: begin
        if (clear) state_d = INN2;
      end
      INN2: begin
        if (accept) begin
          // A successful chase outranks all-out / balls-exhausted on the
          // same ball; a tie goes to the defending side.
          if (runs_upd > target_q) begin
            winner_d = TEAM2;
            state_d  = DONE;
          end else if (innings_end) begin
            winner_d = TEAM1;
            state_d  = DONE;
          end
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: state_d = INN1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= INN1;
      target_q      <= '0;
      winner_q      <= TEAM1;
      inning_over_q <= 1'b0;
      game_over_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      target_q      <= target_d;
      winner_q      <= winner_d;
      inning_over_q <= (state_d == BREAK);
      game_over_q   <= (state_d == DONE);
    end
  end

  assign binaryRuns    = runs_cur;
  assign binaryWickets = wkts_cur;
  assign ballCount     = balls_cur[BALL_W-1:0];
  assign inningOver    = inning_over_q;
  assign gameOver      = game_over_q;
  assign winner        = winner_q;

endmodule
